// File: rtl/impact_sram_ctrl.sv
// IMPACT SRAM access sequencer: precharge, wordline access and recovery
// phases for single-word reads and writes behind a valid/ready handshake.
module impact_sram_ctrl #(
  parameter int PRE_CYCLES = 2,
  parameter int WR_CYCLES  = 3,
  parameter int RD_CYCLES  = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] wl,
  output logic [31:0] bl_out,
  output logic [31:0] blb_out,
  output logic        bl_oe,
  input  logic [31:0] bl_in,
  input  logic [31:0] blb_in
);

  typedef enum logic [2:0] {
    IDLE, PRECH, ACC_WR, ACC_RD, RECOVER
  } state_t;

  localparam logic [3:0] PRE_LD = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] WR_LD  = 4'(WR_CYCLES - 1);
  localparam logic [3:0] RD_LD  = 4'(RD_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic        err_q;
  logic [31:0] row;

  assign req_ready = (state == IDLE);
  assign row       = 32'd1 << addr_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      wl        <= '0;
      bl_oe     <= 1'b0;
      bl_out    <= '0;
      blb_out   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= PRECH;
            cnt     <= PRE_LD;
            busy    <= 1'b1;
            bl_oe   <= 1'b1;
            bl_out  <= '1;
            blb_out <= '1;
          end
        end
        PRECH: begin
          if (cnt == 4'd0) begin
            wl <= row;
            if (we_q) begin
              state   <= ACC_WR;
              cnt     <= WR_LD;
              bl_out  <= wdata_q;
              blb_out <= ~wdata_q;
            end else begin
              state   <= ACC_RD;
              cnt     <= RD_LD;
              bl_oe   <= 1'b0;
              bl_out  <= '0;
              blb_out <= '0;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACC_WR: begin
          if (cnt == 4'd0) begin
            state   <= RECOVER;
            wl      <= '0;
            bl_oe   <= 1'b0;
            bl_out  <= '0;
            blb_out <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACC_RD: begin
          if (cnt == 4'd0) begin
            // a bit pair that is not differential marks a failed sense
            data_q <= bl_in;
            err_q  <= |(~(bl_in ^ blb_in));
            state  <= RECOVER;
            wl     <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RECOVER: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b1;
          if (we_q) begin
            rsp_err <= 1'b0;
          end else begin
            rsp_rdata <= data_q;
            rsp_err   <= err_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
